// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit counters.
// Predicts from pc_IF, trains and flags redirects from EX resolution.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_IF,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] predict_pc,
  input  logic                  meet_branch_ID_EX_o,
  input  logic [DATA_WIDTH-1:0] pc_EX,
  input  logic                  branch_decision,
  input  logic [DATA_WIDTH-1:0] branch_target_EX,
  input  logic                  predicted_taken_EX,
  input  logic [DATA_WIDTH-1:0] predicted_pc_EX,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] correct_pc,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int ENTRIES = 2**INDEX_BITS;
  localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

  logic [ENTRIES-1:0]    valid;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] idx_if;
  logic [INDEX_BITS-1:0] idx_ex;
  logic [TAG_W-1:0]      tag_if;
  logic [TAG_W-1:0]      tag_ex;
  logic                  hit_if;
  logic                  hit_ex;

  assign idx_if = pc_IF[INDEX_BITS+1:2];
  assign idx_ex = pc_EX[INDEX_BITS+1:2];
  assign tag_if = pc_IF[DATA_WIDTH-1:INDEX_BITS+2];
  assign tag_ex = pc_EX[DATA_WIDTH-1:INDEX_BITS+2];

  assign hit_if = valid[idx_if] && (tag_q[idx_if] == tag_if);
  assign hit_ex = valid[idx_ex] && (tag_q[idx_ex] == tag_ex);

  assign predict_taken = hit_if & ctr_q[idx_if][1];
  assign predict_pc    = predict_taken ? target_q[idx_if]
                                       : pc_IF + DATA_WIDTH'(4);

  // Comparing full PCs catches both direction and target errors.
  assign correct_pc = branch_decision ? branch_target_EX
                                      : pc_EX + DATA_WIDTH'(4);
  assign mispredict = meet_branch_ID_EX_o &&
                      (predicted_pc_EX != correct_pc);

  logic unused_bits;
  assign unused_bits = ^{pc_IF[1:0], pc_EX[1:0], predicted_taken_EX};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]    <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (meet_branch_ID_EX_o) begin
      branch_count <= branch_count + 32'd1;
      if (mispredict)
        mispredict_count <= mispredict_count + 32'd1;
      if (hit_ex) begin
        if (branch_decision) begin
          if (ctr_q[idx_ex] != 2'b11)
            ctr_q[idx_ex] <= ctr_q[idx_ex] + 2'b01;
          target_q[idx_ex] <= branch_target_EX;
        end else if (ctr_q[idx_ex] != 2'b00) begin
          ctr_q[idx_ex] <= ctr_q[idx_ex] - 2'b01;
        end
      end else if (branch_decision) begin
        valid[idx_ex]    <= 1'b1;
        tag_q[idx_ex]    <= tag_ex;
        target_q[idx_ex] <= branch_target_EX;
        ctr_q[idx_ex]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed plan cases plus random
// traffic against a table model kept in plain integers.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_IF;
  logic        predict_taken;
  logic [31:0] predict_pc;
  logic        meet;
  logic [31:0] pc_EX;
  logic        decision;
  logic [31:0] target_EX;
  logic        ptaken_EX;
  logic [31:0] ppc_EX;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_IF               (pc_IF),
    .predict_taken       (predict_taken),
    .predict_pc          (predict_pc),
    .meet_branch_ID_EX_o (meet),
    .pc_EX               (pc_EX),
    .branch_decision     (decision),
    .branch_target_EX    (target_EX),
    .predicted_taken_EX  (ptaken_EX),
    .predicted_pc_EX     (ppc_EX),
    .mispredict          (mispredict),
    .correct_pc          (correct_pc),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model: each slot remembers the full PC that owns it.
  bit          m_valid [16];
  int unsigned m_owner [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_br;
  int unsigned m_mis;

  function automatic int slot(input int unsigned pc);
    return (pc / 4) % 16;
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    int s;
    s = slot(pc);
    return m_valid[s] && (m_owner[s] / 64 == pc / 64);
  endfunction

  function automatic bit m_ptaken(input int unsigned pc);
    return m_hit(pc) && m_ctr[slot(pc)] >= 2;
  endfunction

  function automatic int unsigned m_ppc(input int unsigned pc);
    return m_ptaken(pc) ? m_tgt[slot(pc)] : pc + 4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_owner[i] = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic step(input bit r, input int unsigned pif,
                      input bit mt, input int unsigned pex,
                      input bit dec, input int unsigned tgt,
                      input int unsigned ppc);
    int unsigned corr;
    bit          mis;
    int          s;
    @(negedge clk);
    rst       = r;
    pc_IF     = pif;
    meet      = mt;
    pc_EX     = pex;
    decision  = dec;
    target_EX = tgt;
    ppc_EX    = ppc;
    ptaken_EX = (ppc != pex + 4);
    #1;
    corr = dec ? tgt : pex + 4;
    mis  = mt && (ppc != corr);
    check("predict_taken", 32'(predict_taken), 32'(m_ptaken(pif)));
    check("predict_pc", predict_pc, m_ppc(pif));
    check("correct_pc", correct_pc, corr);
    check("mispredict", 32'(mispredict), 32'(mis));
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (mt) begin
      m_br++;
      if (mis) m_mis++;
      s = slot(pex);
      if (m_hit(pex)) begin
        if (dec) begin
          m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = tgt;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (dec) begin
        m_valid[s] = 1;
        m_owner[s] = pex;
        m_tgt[s]   = tgt;
        m_ctr[s]   = 2;
      end
    end
    #1;
    check("branch_count", branch_count, m_br);
    check("mispredict_count", mispredict_count, m_mis);
  endtask

  task automatic resolve(input int unsigned pif,
                         input int unsigned pex,
                         input bit dec, input int unsigned tgt);
    step(0, pif, 1, pex, dec, tgt, m_ppc(pex));
  endtask

  function automatic int unsigned rand_pc();
    int unsigned t;
    int unsigned i;
    t = $urandom_range(0, 3);
    i = $urandom_range(0, 15);
    return (t << 6) | (i << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    rst = 1; pc_IF = 0; meet = 0; pc_EX = 0;
    decision = 0; target_EX = 0; ptaken_EX = 0; ppc_EX = 0;
    m_reset();
    repeat (2) @(posedge clk);

    // Reset state and first allocation.
    step(0, 32'h100, 0, 0, 0, 0, 0);
    step(0, 32'h100, 1, 32'h100, 1, 32'h80, 32'h104);
    #1;
    check("alloc_pred_pc", predict_pc, 32'h80);

    // Training: taken, then not-taken down to and past zero.
    resolve(32'h100, 32'h100, 1, 32'h80);
    resolve(32'h100, 32'h100, 0, 0);
    resolve(32'h100, 32'h100, 0, 0);
    resolve(32'h100, 32'h100, 0, 0);
    resolve(32'h100, 32'h100, 0, 0);
    step(0, 32'h100, 0, 0, 0, 0, 0);

    // Aliasing on the same slot.
    resolve(32'h100, 32'h140, 1, 32'h200);
    step(0, 32'h100, 0, 0, 0, 0, 0);
    step(0, 32'h140, 0, 0, 0, 0, 0);

    // Wrong target on a strongly-taken entry.
    resolve(32'h100, 32'h100, 1, 32'h80);
    resolve(32'h100, 32'h100, 1, 32'h80);
    step(0, 32'h100, 1, 32'h100, 1, 32'h90, 32'h80);
    step(0, 32'h100, 0, 0, 0, 0, 0);
    check("retarget_pc", predict_pc, 32'h90);

    // Reset on the same edge as a taken resolution.
    step(1, 32'h200, 1, 32'h200, 1, 32'h300, 32'h204);
    step(0, 32'h200, 0, 0, 0, 0, 0);
    check("rst_pred_pc", predict_pc, 32'h204);

    // Random traffic over a small PC pool to force hits and aliases.
    for (int n = 0; n < 400; n++) begin
      int unsigned pex;
      int unsigned ppc;
      pex = rand_pc();
      ppc = ($urandom_range(0, 3) == 0) ? rand_pc() : m_ppc(pex);
      step(0, rand_pc(), ($urandom_range(0, 3) != 0), pex,
           $urandom_range(0, 1), rand_pc() & ~32'h3, ppc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
